// File: rtl/serial_vector_encoder.sv
// serial_vector_encoder
// Streams a captured vector of signed fixed-point words to a byte-wide UART
// transmitter. A frame is a header byte, then each word least-significant
// byte first, then an optional modulo-256 checksum of the data bytes.
// A new byte is issued only on a rising edge of transmit_available.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | available=1, waiting for ready && transmit_available
//   HEADER   | header byte on the wire, waiting to send word 0 byte 0
//   DATA     | data byte on the wire, waiting to send the next one
//   CHECKSUM | checksum byte on the wire, waiting to return to IDLE

module serial_vector_encoder #(
    parameter int         NUMBER_BITS     = 37,
    parameter int         NUMBER_BYTES    = 5,
    parameter int         BYTE_INDEX_BITS = 3,
    parameter int         NUM_WORDS       = 4,
    parameter int         WORD_INDEX_BITS = 2,
    parameter bit         SIGN_EXTEND     = 1'b1,
    parameter logic [7:0] HEADER_BYTE     = 8'hA5,
    parameter bit         USE_CHECKSUM    = 1'b1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_WORDS*NUMBER_BITS-1:0] nums,
    input  logic                             ready,
    output logic                             available,
    output logic [7:0]                       transmit_byte,
    output logic                             transmit_ready,
    input  logic                             transmit_available
);

    localparam int PAD_BITS = NUMBER_BYTES * 8;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_HEADER   = 2'd1;
    localparam logic [1:0] S_DATA     = 2'd2;
    localparam logic [1:0] S_CHECKSUM = 2'd3;

    logic [1:0]                       r_state;
    logic [NUM_WORDS*NUMBER_BITS-1:0] r_vec;
    logic [WORD_INDEX_BITS-1:0]       r_word;
    logic [BYTE_INDEX_BITS-1:0]       r_byte;
    logic [7:0]                       r_csum;
    logic                             r_tx_avail_last;
    logic                             r_available;
    logic [7:0]                       r_tx_byte;
    logic                             r_tx_ready;

    logic [NUM_WORDS*PAD_BITS-1:0]    w_padded;
    logic                             w_advance;
    logic                             w_last_byte_of_word;
    logic                             w_last_word;
    logic [WORD_INDEX_BITS-1:0]       w_next_word;
    logic [BYTE_INDEX_BITS-1:0]       w_next_byte;
    logic [7:0]                       w_cur_data;
    logic [7:0]                       w_next_data;
    logic [7:0]                       w_csum_plus;

    // Each captured word widened to whole bytes; pad bits copy the sign or are zero.
    genvar g_k, g_j;
    generate
        for (g_k = 0; g_k < NUM_WORDS; g_k++) begin : g_word
            for (g_j = 0; g_j < PAD_BITS; g_j++) begin : g_bit
                if (g_j < NUMBER_BITS) begin : g_data
                    assign w_padded[g_k*PAD_BITS + g_j] = r_vec[g_k*NUMBER_BITS + g_j];
                end else if (SIGN_EXTEND) begin : g_sign
                    assign w_padded[g_k*PAD_BITS + g_j] = r_vec[g_k*NUMBER_BITS + NUMBER_BITS - 1];
                end else begin : g_zero
                    assign w_padded[g_k*PAD_BITS + g_j] = 1'b0;
                end
            end
        end
    endgenerate

    // Only a 0->1 transition of transmit_available moves the frame forward.
    assign w_advance   = transmit_available & ~r_tx_avail_last;
    assign w_csum_plus = r_csum + w_cur_data;

    // Position bookkeeping: where the current byte sits and which one follows it.
    always_comb begin
        w_last_byte_of_word = (r_byte == BYTE_INDEX_BITS'(NUMBER_BYTES - 1));
        w_last_word         = (r_word == WORD_INDEX_BITS'(NUM_WORDS - 1));
        if (w_last_byte_of_word) begin
            w_next_byte = '0;
            w_next_word = r_word + 1'b1;
        end else begin
            w_next_byte = r_byte + 1'b1;
            w_next_word = r_word;
        end
    end

    // Byte selection for the current position and for the following position.
    always_comb begin
        w_cur_data  = 8'h00;
        w_next_data = 8'h00;
        for (int k = 0; k < NUM_WORDS; k++) begin
            for (int b = 0; b < NUMBER_BYTES; b++) begin
                if (r_word == WORD_INDEX_BITS'(k) && r_byte == BYTE_INDEX_BITS'(b)) begin
                    w_cur_data = w_padded[(k*NUMBER_BYTES + b)*8 +: 8];
                end
                if (w_next_word == WORD_INDEX_BITS'(k) && w_next_byte == BYTE_INDEX_BITS'(b)) begin
                    w_next_data = w_padded[(k*NUMBER_BYTES + b)*8 +: 8];
                end
            end
        end
    end

    // Frame sequencer: capture, header, data bytes, checksum, one strobe per advance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_vec           <= '0;
            r_word          <= '0;
            r_byte          <= '0;
            r_csum          <= 8'h00;
            r_tx_avail_last <= 1'b0;
            r_available     <= 1'b1;
            r_tx_byte       <= 8'h00;
            r_tx_ready      <= 1'b0;
        end else begin
            r_tx_avail_last <= transmit_available;
            r_tx_ready      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ready && transmit_available) begin
                        r_vec       <= nums;
                        r_tx_byte   <= HEADER_BYTE;
                        r_tx_ready  <= 1'b1;
                        r_available <= 1'b0;
                        r_csum      <= 8'h00;
                        r_word      <= '0;
                        r_byte      <= '0;
                        r_state     <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    // Counters are already at word 0 byte 0 from acceptance.
                    if (w_advance) begin
                        r_tx_byte  <= w_cur_data;
                        r_tx_ready <= 1'b1;
                        r_state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_advance) begin
                        r_csum <= w_csum_plus;
                        if (w_last_byte_of_word && w_last_word) begin
                            if (USE_CHECKSUM) begin
                                r_tx_byte  <= w_csum_plus;
                                r_tx_ready <= 1'b1;
                                r_state    <= S_CHECKSUM;
                            end else begin
                                r_available <= 1'b1;
                                r_state     <= S_IDLE;
                            end
                        end else begin
                            r_word     <= w_next_word;
                            r_byte     <= w_next_byte;
                            r_tx_byte  <= w_next_data;
                            r_tx_ready <= 1'b1;
                        end
                    end
                end
                S_CHECKSUM: begin
                    if (w_advance) begin
                        r_available <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_available <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign available      = r_available;
    assign transmit_byte  = r_tx_byte;
    assign transmit_ready = r_tx_ready;

endmodule

// File: doc/serial_vector_encoder.md
# serial_vector_encoder

Frames a vector of NUM_WORDS signed fixed-point numbers and feeds it to the UART transmitter one byte at a time. This is the multi-word successor to the single-number serial encoder, used to stream amplitude and state vectors from the compiler datapath back to the host. Each frame is a header byte, then every word's bytes least-significant byte first, then an optional modulo-256 checksum. The vector is captured on acceptance, so the producer does not have to hold its inputs during transmission.

## Interface
- NUMBER_BITS, 37, bits per signed word
- NUMBER_BYTES, 5, bytes per word on the wire; must satisfy NUMBER_BYTES*8 >= NUMBER_BITS
- BYTE_INDEX_BITS, 3, width of the byte-within-word counter
- NUM_WORDS, 4, words per frame (>= 1)
- WORD_INDEX_BITS, 2, width of the word counter
- SIGN_EXTEND, 1, pad bits above NUMBER_BITS: 1 = copy the word's sign bit, 0 = zero
- HEADER_BYTE, 8'hA5, first byte of every frame
- USE_CHECKSUM, 1, 1 = append a checksum byte
- clk  in  1  the single clock; all logic is on posedge clk
- reset  in  1  synchronous, active-low reset
- nums  in  NUM_WORDS*NUMBER_BITS  packed vector; word k is nums[k*NUMBER_BITS +: NUMBER_BITS]
- ready  in  1  producer requests a frame
- available  out  1  high when idle and able to accept a frame
- transmit_byte  out  8  byte presented to the transmitter
- transmit_ready  out  1  one-cycle strobe: transmit_byte is valid
- transmit_available  in  1  transmitter idle

## Operation
- States: IDLE, HEADER, DATA, CHECKSUM.
- Frame length is 1 + NUM_WORDS*NUMBER_BYTES + USE_CHECKSUM bytes; 22 at the defaults.
- **Reset (reset==0 at a clock edge):**
  - State goes to IDLE, available=1, transmit_ready=0, transmit_byte=8'h00.
  - Word and byte counters, checksum accumulator, captured vector and the transmit_available history register all clear to 0.
  - Reset mid-frame abandons the frame immediately. No further strobes are issued.
- **IDLE:** when ready && transmit_available:
  - capture nums into the internal vector register;
  - set transmit_byte=HEADER_BYTE and pulse transmit_ready;
  - clear available, clear the checksum, set word=0 and byte=0;
  - go to HEADER.
  - With ready high and transmit_available low, stay in IDLE.
- **Advance event:** a rising edge of transmit_available, i.e. the registered previous value was 0 and the current value is 1. Outside IDLE, each advance event issues exactly one next byte. Level-high transmit_available never advances by itself.
- **HEADER:** on advance, issue word 0 byte 0 and go to DATA.
- **DATA:** on advance:
  - add the current data byte into the checksum (mod 256);
  - if bytes remain, increment byte; on wrap from NUMBER_BYTES-1 to 0, increment word; then issue the next byte;
  - after the last byte of word NUM_WORDS-1: if USE_CHECKSUM, issue the checksum (including the final byte) and go to CHECKSUM; otherwise go to IDLE and set available=1 with no strobe.
- **CHECKSUM:** on advance, go to IDLE and set available=1.
- **Byte mapping:**
  - byte b of word k carries bit i = word bit b*8+i when b*8+i < NUMBER_BITS;
  - otherwise it carries the sign bit (SIGN_EXTEND=1) or 0.
- **Checksum:** 8-bit sum of all data bytes, header excluded, carries discarded.
- ready while busy is ignored. nums changes after capture do not affect the frame in flight.

## Timing
- All outputs are registered.
- Acceptance: ready && transmit_available sampled at edge N gives transmit_ready=1 and transmit_byte=HEADER_BYTE during cycle N+1, and available=0 from N+1.
- Each next byte: an advance event sampled at edge M gives the strobe and the new byte during cycle M+1.
- transmit_byte holds its value until the next strobe. transmit_ready is never high for two consecutive cycles.
- Frame end: the advance event at edge M after the last byte gives available=1 in cycle M+1. A new acceptance is possible at edge M+1 at the earliest.
- Edge detection: at edge N, transmit_available_last samples transmit_available and takes the value 1. An advance event therefore needs the transmitter to drop and re-raise transmit_available.

## Test plan
- Defaults, nums word0=37'h0012345678, words1..3=0, transmitter modelled as busy for 10 cycles per byte -> wire bytes A5, 78 56 34 12 00, then 15 x 00, checksum 8'h14; 22 strobes total; available returns high.
- SIGN_EXTEND=1, word0=-1 (37'h1FFFFFFFFF) -> word 0 sent as FF FF FF FF FF. With SIGN_EXTEND=0 -> FF FF FF FF 1F.
- USE_CHECKSUM=0, NUM_WORDS=1 -> exactly 6 strobes. available rises one cycle after the 6th advance event.
- transmit_available held high throughout, no edges -> only the header strobe is issued and the block stays in HEADER.
- Change nums and pulse ready mid-frame -> frame content unchanged, no extra strobes.
- reset=0 during DATA -> next cycle available=1, transmit_ready=0. A following ready starts a fresh frame with HEADER_BYTE.
